// File: rtl/eth_rx_port_arbiter.sv
// Packet-level round-robin merge of four 10G MAC rx AXI-Stream ports into one stream,
// tagging each packet with its source port and truncating packets longer than MAX_BEATS.
module eth_rx_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 1200
) (
    input  logic                                   rx_axis_fifo_aclk,
    input  logic                                   reset,
    input  logic [NUM_PORTS-1:0]                   port_en,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]       s_axis_tdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]     s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
    output logic [NUM_PORTS-1:0]                   s_axis_tready,
    output logic [DATA_W-1:0]                      m_axis_tdata,
    output logic [DATA_W/8-1:0]                    m_axis_tkeep,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    output logic [$clog2(NUM_PORTS)-1:0]           m_axis_tdest,
    output logic                                   m_axis_terr,
    input  logic                                   m_axis_tready,
    output logic [15:0]                            trunc_cnt
);

    localparam int          PW        = $clog2(NUM_PORTS);
    localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DROP
    } state_t;

    state_t                state_reg, state_next;
    logic [PW-1:0]         grant_reg, grant_next;
    logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [15:0]           beat_cnt_reg, beat_cnt_next;
    logic [15:0]           trunc_cnt_reg, trunc_cnt_next;

    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  cand_req;
    logic [PW-1:0]         cand_idx [NUM_PORTS];
    logic [PW-1:0]         winner;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  at_limit;

    // cand_idx[k] is the port k positions after the round-robin pointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign req[gi]      = s_axis_tvalid[gi] & port_en[gi];
            assign cand_idx[gi] = rr_ptr_reg + PW'(gi);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = rr_ptr_reg;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                winner = cand_idx[k];
            end
        end
    end

    assign sel_valid    = s_axis_tvalid[grant_reg];
    assign sel_last     = s_axis_tlast[grant_reg];
    assign at_limit     = (beat_cnt_reg == LAST_BEAT);
    assign m_axis_tdest = grant_reg;
    assign trunc_cnt    = trunc_cnt_reg;

    always_ff @(posedge rx_axis_fifo_aclk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            beat_cnt_reg  <= '0;
            trunc_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            trunc_cnt_reg <= trunc_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        beat_cnt_next  = beat_cnt_reg;
        trunc_cnt_next = trunc_cnt_reg;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_terr    = 1'b0;
        s_axis_tready  = '0;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    grant_next    = winner;
                    beat_cnt_next = '0;
                    state_next    = XFER;
                end
            end

            XFER: begin
                m_axis_tdata             = s_axis_tdata[grant_reg];
                m_axis_tkeep             = s_axis_tkeep[grant_reg];
                m_axis_tvalid            = sel_valid;
                m_axis_tlast             = sel_valid & (sel_last | at_limit);
                m_axis_terr              = sel_valid & at_limit & ~sel_last;
                s_axis_tready[grant_reg] = m_axis_tready;
                if (sel_valid && m_axis_tready) begin
                    beat_cnt_next = beat_cnt_reg + 16'd1;
                    if (sel_last) begin
                        rr_ptr_next = grant_reg + PW'(1);
                        state_next  = IDLE;
                    end else if (at_limit) begin
                        if (trunc_cnt_reg != 16'hFFFF) begin
                            trunc_cnt_next = trunc_cnt_reg + 16'd1;
                        end
                        state_next = DROP;
                    end
                end
            end

            // Swallow the rest of a truncated packet so the source can move on
            DROP: begin
                s_axis_tready[grant_reg] = 1'b1;
                if (sel_valid && sel_last) begin
                    rr_ptr_next = grant_reg + PW'(1);
                    state_next  = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_rx_port_arbiter.sv
// Randomized bench for eth_rx_port_arbiter: per-port packet queues feed the sources, and a
// monitor checks merged beats, grant order, handshakes and truncation against a packet model.
module tb_eth_rx_port_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 64;
    localparam int KW   = DW / 8;
    localparam int MAXB = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          err;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          port_en;
    logic [NP-1:0][DW-1:0]  s_tdata;
    logic [NP-1:0][KW-1:0]  s_tkeep;
    logic [NP-1:0]          s_tvalid;
    logic [NP-1:0]          s_tlast;
    logic [NP-1:0]          s_tready;
    logic [DW-1:0]          m_tdata;
    logic [KW-1:0]          m_tkeep;
    logic                   m_tvalid;
    logic                   m_tlast;
    logic [1:0]             m_tdest;
    logic                   m_terr;
    logic                   m_tready;
    logic [15:0]            trunc_cnt;

    beat_t txq  [NP][$];
    beat_t expq [NP][$];
    int    pkts_left [NP];
    int    last_served;
    int    model_trunc;
    bit    in_pkt;
    logic [1:0] cur_dest;
    int    vectors;
    int    miscompares;
    int    ready_pct;
    int    bubble_pct;
    bit    force_all;
    bit    gap_check;
    int    cyc;
    int    last_end_cyc;
    logic [NP-1:0] hs;
    bit    drv_mid [NP];

    always #5 clk = ~clk;

    eth_rx_port_arbiter #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .MAX_BEATS (MAXB)
    ) dut (
        .rx_axis_fifo_aclk (clk),
        .reset             (rst),
        .port_en           (port_en),
        .s_axis_tdata      (s_tdata),
        .s_axis_tkeep      (s_tkeep),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tkeep      (m_tkeep),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tlast      (m_tlast),
        .m_axis_tdest      (m_tdest),
        .m_axis_terr       (m_terr),
        .m_axis_tready     (m_tready),
        .trunc_cnt         (trunc_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet model: beats up to MAX_BEATS pass unchanged; beat MAX_BEATS closes the packet
    // and is flagged as an error if the source had more to send; the rest never appear.
    task automatic push_pkt(input int p, input int len);
        beat_t b;
        for (int i = 1; i <= len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = (i == len) ? (8'($urandom_range(255)) | 8'h01) : 8'hFF;
            b.last = (i == len);
            b.err  = 1'b0;
            txq[p].push_back(b);
            if (i < MAXB) begin
                expq[p].push_back(b);
            end else if (i == MAXB) begin
                b.err  = (len > MAXB);
                b.last = 1'b1;
                expq[p].push_back(b);
            end
        end
        if (len > MAXB) model_trunc++;
        pkts_left[p]++;
    endtask

    task automatic wait_drain(input logic [NP-1:0] mask);
        int  n;
        bit  busy;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            busy = 0;
            for (int p = 0; p < NP; p++) begin
                if (mask[p] && (expq[p].size() > 0 || txq[p].size() > 0)) busy = 1;
            end
        end while (busy && n < 5000);
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: port queues still busy after %0d cycles", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic flush_model();
        for (int p = 0; p < NP; p++) begin
            txq[p].delete();
            expq[p].delete();
            pkts_left[p] = 0;
        end
        last_served  = NP - 1;
        model_trunc  = 0;
        in_pkt       = 0;
        last_end_cyc = -1;
    endtask

    // Source and downstream-ready driver; acts just after each rising edge
    initial begin
        beat_t b;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        for (int p = 0; p < NP; p++) drv_mid[p] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && txq[p].size() > 0) begin
                    b = txq[p].pop_front();
                    drv_mid[p] = !b.last;
                end
                if (force_all) begin
                    s_tvalid[p] = 1'b1;
                    s_tdata[p]  = {$urandom, $urandom};
                    s_tkeep[p]  = 8'hFF;
                    s_tlast[p]  = 1'b1;
                end else if (txq[p].size() == 0) begin
                    s_tvalid[p] = 1'b0;
                    drv_mid[p]  = 0;
                end else if (s_tvalid[p] && !hs[p]) begin
                    // beat offered but not taken yet: keep it stable
                end else if (drv_mid[p] && $urandom_range(99) < bubble_pct) begin
                    s_tvalid[p] = 1'b0;
                end else begin
                    s_tvalid[p] = 1'b1;
                    s_tdata[p]  = txq[p][0].data;
                    s_tkeep[p]  = txq[p][0].keep;
                    s_tlast[p]  = txq[p][0].last;
                end
            end
            m_tready = force_all || ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        beat_t        b;
        int           w;
        int           idx;
        bit           prev_stall;
        logic [127:0] stall_val;
        prev_stall = 0;
        stall_val  = '0;
        cyc        = 0;
        hs         = '0;
        forever begin
            @(negedge clk);
            cyc++;
            hs = s_tvalid & s_tready;
            if (rst) begin
                prev_stall = 0;
                in_pkt     = 0;
                continue;
            end
            if (m_tvalid) begin
                chk("s_tready", 128'(s_tready), 128'(m_tready ? (4'b0001 << m_tdest) : 4'b0000));
                if (prev_stall) chk("stall_hold", 128'({m_tdata, m_tkeep, m_tlast, m_tdest}), stall_val);
                if (m_tready) begin
                    if (!in_pkt) begin
                        w = -1;
                        for (int k = 1; k <= NP; k++) begin
                            idx = (last_served + k) % NP;
                            if (w < 0 && pkts_left[idx] > 0 && port_en[idx]) w = idx;
                        end
                        chk("grant", 128'(m_tdest), 128'(w));
                        if (gap_check && last_end_cyc >= 0) chk("gap", 128'(cyc - last_end_cyc), 128'(2));
                        if (pkts_left[m_tdest] > 0) pkts_left[m_tdest]--;
                        last_served = int'(m_tdest);
                        cur_dest    = m_tdest;
                    end else begin
                        chk("tdest_hold", 128'(m_tdest), 128'(cur_dest));
                    end
                    if (expq[m_tdest].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL beat: unexpected beat from port %0d data %0h", m_tdest, m_tdata);
                    end else begin
                        b = expq[m_tdest].pop_front();
                        chk("beat", 128'({m_tdata, m_tkeep, m_tlast, m_terr}),
                            128'({b.data, b.keep, b.last, b.err}));
                    end
                    in_pkt = !m_tlast;
                    if (m_tlast) last_end_cyc = cyc;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    stall_val  = 128'({m_tdata, m_tkeep, m_tlast, m_tdest});
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        ready_pct   = 100;
        bubble_pct  = 0;
        gap_check   = 0;
        force_all   = 1;
        port_en     = '1;
        rst         = 1'b1;
        flush_model();

        // Reset with every input active
        repeat (3) @(negedge clk);
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_m_data",   128'({m_tdata, m_tkeep}), 128'(0));
        chk("rst_m_flags",  128'({m_tlast, m_terr, m_tdest}), 128'(0));
        chk("rst_trunc",    128'(trunc_cnt), 128'(0));
        force_all = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin with 3-beat packets and one idle cycle between packets
        gap_check    = 1;
        last_end_cyc = -1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) push_pkt(p, 3);
        wait_drain(4'hF);
        gap_check = 0;

        // Masking: port 3 requests but is disabled, then enabled
        port_en = 4'b0111;
        for (int r = 0; r < 4; r++) begin
            push_pkt(1, $urandom_range(1, 5));
            push_pkt(3, $urandom_range(1, 5));
        end
        wait_drain(4'b0010);
        chk("masked_port3_pending", 128'(pkts_left[3]), 128'(4));
        port_en = 4'b1010;
        for (int r = 0; r < 4; r++) push_pkt(1, $urandom_range(1, 5));
        wait_drain(4'b1010);

        // Backpressure on port 2
        port_en    = 4'hF;
        ready_pct  = 40;
        bubble_pct = 20;
        for (int r = 0; r < 3; r++) push_pkt(2, 6);
        wait_drain(4'hF);

        // Watchdog: 12-beat packet truncated, 8-beat packet passes untouched
        ready_pct  = 100;
        bubble_pct = 0;
        push_pkt(0, 12);
        push_pkt(1, MAXB);
        wait_drain(4'hF);
        chk("trunc_after_wd", 128'(trunc_cnt), 128'(model_trunc));

        // Random traffic
        ready_pct  = 75;
        bubble_pct = 15;
        for (int p = 0; p < NP; p++) begin
            n = $urandom_range(2, 5);
            for (int r = 0; r < n; r++) push_pkt(p, $urandom_range(1, 14));
        end
        wait_drain(4'hF);
        chk("trunc_after_rand", 128'(trunc_cnt), 128'(model_trunc));

        // Reset in the middle of beat 3 of a port 1 packet
        ready_pct  = 100;
        bubble_pct = 0;
        push_pkt(1, 6);
        n = 0;
        while (txq[1].size() > 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midpkt_reached", 128'(txq[1].size() <= 4), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_s_tready", 128'(s_tready), 128'(0));
        chk("async_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("async_m_data",   128'({m_tdata, m_tkeep}), 128'(0));
        chk("async_m_flags",  128'({m_tlast, m_terr, m_tdest}), 128'(0));
        chk("async_trunc",    128'(trunc_cnt), 128'(0));
        flush_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int p = 0; p < NP; p++) push_pkt(p, $urandom_range(1, 4));
        wait_drain(4'hF);
        chk("trunc_after_reset", 128'(trunc_cnt), 128'(model_trunc));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
